// File: rtl/aes_key_schedule_if.sv
// Purpose: bundles the round-controller <-> key-schedule handshake and key bus.
// Latency: none (wires only).
// Backpressure: none; 'next' is a single-cycle advance request from the controller.
//
// Signals:
//   start     - load key_in and begin a schedule (controller -> schedule)
//   key_in    - 128-bit cipher key, byte 0 in [127:120]
//   next      - advance to the next round key
//   round_key - current round key (schedule -> XOR stage)
//   round_num - index of round_key, 0..10
//   key_valid - round_key holds a valid schedule key
//   done      - one-cycle pulse after the last round key is consumed
//   rd_idx    - keystore read index   (AES_KEYSTORE_EN builds only)
//   rd_key    - keystore read data    (AES_KEYSTORE_EN builds only)
interface aes_key_schedule_if;
    logic         start;
    logic [127:0] key_in;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         done;
`ifdef AES_KEYSTORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key_in, next, rd_idx,
        input  round_key, round_num, key_valid, done, rd_key
    );
    modport slave (
        input  start, key_in, next, rd_idx,
        output round_key, round_num, key_valid, done, rd_key
    );
`else
    modport master (
        output start, key_in, next,
        input  round_key, round_num, key_valid, done
    );
    modport slave (
        input  start, key_in, next,
        output round_key, round_num, key_valid, done
    );
`endif
endinterface

// File: rtl/aes_key_schedule.sv
// Purpose: sequential AES-128 key expansion; holds the current round key for the XOR stage.
// Latency: key_valid/round key 0 one cycle after start; each later round key one cycle after next.
// Backpressure: none; the controller paces the schedule with next, which may be held every cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   ks_if  - aes_key_schedule_if.slave (start, key_in, next in; round_key, round_num,
//            key_valid, done out; rd_idx in / rd_key out when the keystore is built)
// Optional build: define AES_KEYSTORE_EN to add an 11-entry round-key store readable
// through rd_idx/rd_key, so the inverse cipher can walk keys 10..0 without re-expanding.
module aes_key_schedule #(
    parameter int NR = 10
) (
    input logic           clk,
    input logic           rst,
    aes_key_schedule_if.slave ks_if
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // AES forward S-box
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_e       state_q,     state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_num_q, round_num_d;
    logic         key_valid_q, key_valid_d;
    logic         done_q,      done_d;
    logic [7:0]   rcon_q,      rcon_d;

    // ------------------------------------------------------------------
    // One expansion step from the current round key (single cycle).
    // ------------------------------------------------------------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] exp_key;
    logic [7:0]   rcon_nxt;

    always_comb begin
        w0 = round_key_q[127:96];
        w1 = round_key_q[95:64];
        w2 = round_key_q[63:32];
        w3 = round_key_q[31:0];
        // RotWord moves the leading byte of w3 to the tail
        rot_w = {w3[23:0], w3[31:24]};
        sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                 SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
        t_w   = sub_w ^ {rcon_q, 24'h0};
        n0    = w0 ^ t_w;
        n1    = w1 ^ n0;
        n2    = w2 ^ n1;
        n3    = w3 ^ n2;
        exp_key = {n0, n1, n2, n3};
        // GF(2^8) doubling; after 80 the sequence wraps to 1B, 36
        rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

`ifdef AES_KEYSTORE_EN
    logic [127:0] ks_q [0:NR];
    logic [127:0] ks_d [0:NR];
    logic [127:0] rd_key_c;
`endif

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_num_d = round_num_q;
        key_valid_d = key_valid_q;
        done_d      = 1'b0;
        rcon_d      = rcon_q;
`ifdef AES_KEYSTORE_EN
        ks_d        = ks_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // next is ignored here; only start can leave IDLE
                if (ks_if.start) begin
                    state_d     = ST_ACTIVE;
                    round_key_d = ks_if.key_in;
                    round_num_d = 4'd0;
                    key_valid_d = 1'b1;
                    rcon_d      = 8'h01;
`ifdef AES_KEYSTORE_EN
                    ks_d[0]     = ks_if.key_in;
`endif
                end
            end
            ST_ACTIVE: begin
                // start is ignored here; the loaded key cannot be replaced mid-schedule
                if (ks_if.next) begin
                    if (round_num_q == LAST_ROUND) begin
                        // round_key/round_num keep the final key for the XOR stage
                        key_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        round_key_d = exp_key;
                        round_num_d = round_num_q + 4'd1;
                        rcon_d      = rcon_nxt;
`ifdef AES_KEYSTORE_EN
                        // entry k tracks round key k on the same edge
                        for (int k = 1; k <= NR; k++) begin
                            if (round_num_d == 4'(k)) ks_d[k] = exp_key;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            round_key_q <= '0;
            round_num_q <= '0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            rcon_q      <= 8'h01;
`ifdef AES_KEYSTORE_EN
            ks_q        <= '{default: '0};
`endif
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_num_q <= round_num_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
            rcon_q      <= rcon_d;
`ifdef AES_KEYSTORE_EN
            ks_q        <= ks_d;
`endif
        end
    end

`ifdef AES_KEYSTORE_EN
    // Combinational read; indices past the last round read as zero
    always_comb begin
        rd_key_c = '0;
        for (int k = 0; k <= NR; k++) begin
            if (ks_if.rd_idx == 4'(k)) rd_key_c = ks_q[k];
        end
    end
    assign ks_if.rd_key = rd_key_c;
`endif

    assign ks_if.round_key = round_key_q;
    assign ks_if.round_num = round_num_q;
    assign ks_if.key_valid = key_valid_q;
    assign ks_if.done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Purpose: directed self-checking bench for aes_key_schedule using FIPS-197 vectors.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked at the same point.
// Backpressure: none; next is driven back-to-back and with idle gaps.
module tb_aes_key_schedule;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_schedule_if ks_if();

    aes_key_schedule #(.NR(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .ks_if (ks_if)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // FIPS-197 appendix A.1 expansion of FIPS_KEY
    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full schedule with 'gap' idle cycles between advances; ends right after the done pulse
    task automatic run_gapped(input int gap);
        ks_if.start  = 1'b1;
        ks_if.key_in = FIPS_KEY;
        tick();
        ks_if.start  = 1'b0;
        ks_if.key_in = '1;
        check_eq($sformatf("gap%0d_load_valid", gap), 128'(ks_if.key_valid), 128'd1);
        check_eq($sformatf("gap%0d_rk0", gap), ks_if.round_key, fips_rk[0]);
        for (int r = 1; r <= 10; r++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                check_eq($sformatf("gap%0d_hold_r%0d", gap, r - 1), ks_if.round_key, fips_rk[r - 1]);
            end
            ks_if.next = 1'b1;
            tick();
            ks_if.next = 1'b0;
            check_eq($sformatf("gap%0d_rn%0d", gap, r), 128'(ks_if.round_num), 128'(r));
            check_eq($sformatf("gap%0d_rk%0d", gap, r), ks_if.round_key, fips_rk[r]);
        end
        ks_if.next = 1'b1;
        tick();
        ks_if.next = 1'b0;
        check_eq($sformatf("gap%0d_done", gap), 128'(ks_if.done), 128'd1);
    endtask

    initial begin
        rst          = 1'b0;
        ks_if.start  = 1'b0;
        ks_if.key_in = '0;
        ks_if.next   = 1'b0;
`ifdef AES_KEYSTORE_EN
        ks_if.rd_idx = 4'd0;
`endif
        #12;
        check_eq("rst_round_key", ks_if.round_key, 128'h0);
        check_eq("rst_round_num", 128'(ks_if.round_num), 128'd0);
        check_eq("rst_key_valid", 128'(ks_if.key_valid), 128'd0);
        check_eq("rst_done", 128'(ks_if.done), 128'd0);
        rst = 1'b1;
        tick();

        // Load; key_in changes afterwards must not matter
        ks_if.start  = 1'b1;
        ks_if.key_in = FIPS_KEY;
        tick();
        ks_if.start  = 1'b0;
        ks_if.key_in = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        check_eq("load_key_valid", 128'(ks_if.key_valid), 128'd1);
        check_eq("load_round_num", 128'(ks_if.round_num), 128'd0);
        check_eq("load_round_key", ks_if.round_key, fips_rk[0]);

        // Back-to-back advances
        ks_if.next = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            tick();
            check_eq($sformatf("b2b_rn%0d", r), 128'(ks_if.round_num), 128'(r));
            check_eq($sformatf("b2b_rk%0d", r), ks_if.round_key, fips_rk[r]);
        end
        tick();
        check_eq("final_done", 128'(ks_if.done), 128'd1);
        check_eq("final_key_valid", 128'(ks_if.key_valid), 128'd0);
        check_eq("final_rk_hold", ks_if.round_key, fips_rk[10]);
        check_eq("final_rn_hold", 128'(ks_if.round_num), 128'd10);
        ks_if.next = 1'b0;
        tick();
        check_eq("done_one_cycle", 128'(ks_if.done), 128'd0);

        // next while IDLE is ignored
        ks_if.next = 1'b1;
        tick();
        check_eq("idle_next_done", 128'(ks_if.done), 128'd0);
        check_eq("idle_next_valid", 128'(ks_if.key_valid), 128'd0);
        check_eq("idle_next_rk", ks_if.round_key, fips_rk[10]);
        check_eq("idle_next_rn", 128'(ks_if.round_num), 128'd10);
        ks_if.next = 1'b0;
        tick();

        // Gapped advances, each restarted on the cycle right after done
        run_gapped(1);
        run_gapped(3);

        // Ignored start while ACTIVE
        ks_if.start  = 1'b1;
        ks_if.key_in = FIPS_KEY;
        tick();
        ks_if.start  = 1'b0;
        ks_if.next   = 1'b1;
        repeat (4) tick();
        ks_if.next   = 1'b0;
        check_eq("pre_ign_rn", 128'(ks_if.round_num), 128'd4);
        ks_if.start  = 1'b1;
        ks_if.key_in = 128'h0;
        tick();
        check_eq("ign_start_rn", 128'(ks_if.round_num), 128'd4);
        check_eq("ign_start_rk", ks_if.round_key, fips_rk[4]);
        ks_if.next   = 1'b1;
        tick();
        check_eq("start_next_rn", 128'(ks_if.round_num), 128'd5);
        check_eq("start_next_rk", ks_if.round_key, fips_rk[5]);
        ks_if.start  = 1'b0;
        tick();
        ks_if.next   = 1'b0;
        check_eq("pre_rst_rn", 128'(ks_if.round_num), 128'd6);

        // Asynchronous reset in mid-cycle
        #3;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_rk", ks_if.round_key, 128'h0);
        check_eq("mid_rst_rn", 128'(ks_if.round_num), 128'd0);
        check_eq("mid_rst_valid", 128'(ks_if.key_valid), 128'd0);
        check_eq("mid_rst_done", 128'(ks_if.done), 128'd0);
`ifdef AES_KEYSTORE_EN
        ks_if.rd_idx = 4'd4;
        #1;
        check_eq("mid_rst_store", ks_if.rd_key, 128'h0);
`endif
        #1;
        rst = 1'b1;
        tick();

        // Restart after reset
        ks_if.start  = 1'b1;
        ks_if.key_in = FIPS_KEY;
        tick();
        ks_if.start  = 1'b0;
        ks_if.next   = 1'b1;
        tick();
        check_eq("restart_rk1", ks_if.round_key, fips_rk[1]);
        repeat (9) tick();
        check_eq("restart_rk10", ks_if.round_key, fips_rk[10]);
        tick();
        ks_if.next   = 1'b0;
        check_eq("restart_done", 128'(ks_if.done), 128'd1);

`ifdef AES_KEYSTORE_EN
        ks_if.rd_idx = 4'd10;
        #1;
        check_eq("store_rd10", ks_if.rd_key, fips_rk[10]);
        ks_if.rd_idx = 4'd0;
        #1;
        check_eq("store_rd0", ks_if.rd_key, fips_rk[0]);
        ks_if.rd_idx = 4'd5;
        #1;
        check_eq("store_rd5", ks_if.rd_key, fips_rk[5]);
        ks_if.rd_idx = 4'd12;
        #1;
        check_eq("store_rd12", ks_if.rd_key, 128'h0);
`endif
        tick();

        // start and next together in IDLE: only start acts; zero key
        ks_if.start  = 1'b1;
        ks_if.next   = 1'b1;
        ks_if.key_in = 128'h0;
        tick();
        ks_if.start  = 1'b0;
        check_eq("zero_load_rn", 128'(ks_if.round_num), 128'd0);
        check_eq("zero_load_rk", ks_if.round_key, 128'h0);
        check_eq("zero_load_valid", 128'(ks_if.key_valid), 128'd1);
        tick();
        ks_if.next   = 1'b0;
        check_eq("zero_rk1", ks_if.round_key, 128'h62636363626363636263636362636363);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
